// File: rtl/nn_pkg.sv
// Shared constants and FSM encoding for the layer activation loader.
package nn_pkg;

  localparam int DW_DEF    = 16;
  localparam int N_IN_DEF  = 15;
  localparam int IDX_W_DEF = $clog2(N_IN_DEF);

  // FILL collects words; WAIT parks a complete frame until downstream frees up.
  typedef enum logic {
    FILL = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/layer_act_loader.sv
// Writer side of the parallel activation bus feeding a layer of neuron nodes.
// Serial words are gathered into a shadow buffer and committed atomically to
// act_bus. act_bus changes on the commit edge and act_strobe follows one cycle
// later, so nodes always sample a vector that has already settled.
// Optional build macro: LAYER_ACT_CLAMP_EN (ReLU clamp of negative words at ingest).
module layer_act_loader
  import nn_pkg::*;
#(
  parameter int N_IN = N_IN_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DW-1:0]      in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic               hold,
  output logic [N_IN*DW-1:0] act_bus,
  output logic               act_strobe,
  output logic               frame_err,
  output logic [15:0]        frame_cnt
);

  localparam int              IDX_W    = $clog2(N_IN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [N_IN-1:0][DW-1:0]   shadow_q, shadow_d;
  logic [N_IN-1:0][DW-1:0]   bus_q, bus_d;
  logic [15:0]               cnt_q, cnt_d;
  // Final word arrived without in_last while the frame is parked in WAIT.
  logic                      miss_q, miss_d;
  logic                      commit, err_now;
  // Two-stage delay so strobe/err land one cycle after act_bus moves.
  logic                      cmt_q, strobe_q, err1_q, ferr_q;
  logic [DW-1:0]             word_in;

  // Ingest conditioning: bit-exact by default, optional ReLU clamp.
  always_comb begin
`ifdef LAYER_ACT_CLAMP_EN
    word_in = in_data[DW-1] ? '0 : in_data;
`else
    word_in = in_data;
`endif
  end

  // Next-state: frame assembly, framing checks and commit decision.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    bus_d    = bus_q;
    cnt_d    = cnt_q;
    miss_d   = miss_q;
    commit   = 1'b0;
    err_now  = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (idx_q == LAST_IDX) begin
            shadow_d[idx_q] = word_in;
            if (hold) begin
              state_d = WAIT;
              miss_d  = ~in_last;
            end else begin
              commit  = 1'b1;
              err_now = ~in_last;
              idx_d   = '0;
            end
          end else if (in_last) begin
            // Early last: drop this word and the partial frame.
            idx_d   = '0;
            err_now = 1'b1;
          end else begin
            shadow_d[idx_q] = word_in;
            idx_d           = idx_q + 1'b1;
          end
        end
      end
      WAIT: begin
        if (!hold) begin
          commit  = 1'b1;
          err_now = miss_q;
          miss_d  = 1'b0;
          idx_d   = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    // shadow_d already holds the final word when committing from FILL.
    if (commit) begin
      bus_d = shadow_d;
      cnt_d = cnt_q + 16'd1;
    end
  end

  // State and datapath registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FILL;
      idx_q    <= '0;
      shadow_q <= '0;
      bus_q    <= '0;
      cnt_q    <= '0;
      miss_q   <= 1'b0;
      cmt_q    <= 1'b0;
      strobe_q <= 1'b0;
      err1_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      bus_q    <= bus_d;
      cnt_q    <= cnt_d;
      miss_q   <= miss_d;
      cmt_q    <= commit;
      strobe_q <= cmt_q;
      err1_q   <= err_now;
      ferr_q   <= err1_q;
    end
  end

  assign act_bus    = bus_q;
  assign act_strobe = strobe_q;
  assign frame_err  = ferr_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_layer_act_loader.sv
// Directed bench for layer_act_loader (N_IN=15, DW=16).
module tb_layer_act_loader;

  localparam int N  = 15;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [DW-1:0]     in_data;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic              hold;
  logic [N*DW-1:0]   act_bus;
  logic              act_strobe;
  logic              frame_err;
  logic [15:0]       frame_cnt;

  int checks   = 0;
  int failures = 0;

  layer_act_loader #(.N_IN(N), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .hold      (hold),
    .act_bus   (act_bus),
    .act_strobe(act_strobe),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] wd(input int k);
    return {48'b0, act_bus[k*DW +: DW]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  logic [63:0] exp_neg;

  initial begin
    // T1: reset with in_valid asserted
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    in_last  = 1'b1;
    hold     = 1'b0;
    step(); step();
    reset    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("rst_bus_zero", {63'b0, |act_bus}, 64'd0);
    chk("rst_ready",    {63'b0, in_ready}, 64'd1);
    chk("rst_cnt",      {48'b0, frame_cnt}, 64'd0);
    chk("rst_strobe",   {63'b0, act_strobe}, 64'd0);
    chk("rst_err",      {63'b0, frame_err}, 64'd0);

    // T2: clean frame 1..15
    for (int k = 1; k <= 15; k++) send(16'(k), k == 15);
    chk("t2_w0",     wd(0), 64'd1);
    chk("t2_w7",     wd(7), 64'd8);
    chk("t2_w14",    wd(14), 64'd15);
    chk("t2_cnt",    {48'b0, frame_cnt}, 64'd1);
    chk("t2_stb_e0", {63'b0, act_strobe}, 64'd0);
    chk("t2_ready",  {63'b0, in_ready}, 64'd1);
    step();
    chk("t2_stb",    {63'b0, act_strobe}, 64'd1);
    chk("t2_err",    {63'b0, frame_err}, 64'd0);
    step();
    chk("t2_stb_off", {63'b0, act_strobe}, 64'd0);

    // T3: hold during final word of 100..114
    for (int k = 0; k < 14; k++) send(16'(100 + k), 1'b0);
    hold = 1'b1;
    send(16'd114, 1'b1);
    chk("t3_ready0", {63'b0, in_ready}, 64'd0);
    chk("t3_keep_w0", wd(0), 64'd1);
    for (int c = 0; c < 5; c++) step();
    chk("t3_keep_w14", wd(14), 64'd15);
    chk("t3_ready_held", {63'b0, in_ready}, 64'd0);
    chk("t3_no_stb", {63'b0, act_strobe}, 64'd0);
    chk("t3_cnt_held", {48'b0, frame_cnt}, 64'd1);
    hold = 1'b0;
    step();
    chk("t3_w0",    wd(0), 64'd100);
    chk("t3_w14",   wd(14), 64'd114);
    chk("t3_cnt",   {48'b0, frame_cnt}, 64'd2);
    chk("t3_ready", {63'b0, in_ready}, 64'd1);
    step();
    chk("t3_stb",   {63'b0, act_strobe}, 64'd1);
    chk("t3_err",   {63'b0, frame_err}, 64'd0);
    step();

    // T4: early last on 6th word, then clean frame
    for (int k = 0; k < 6; k++) send(16'(200 + k), k == 5);
    chk("t4_err_e0", {63'b0, frame_err}, 64'd0);
    step();
    chk("t4_err",    {63'b0, frame_err}, 64'd1);
    chk("t4_no_stb", {63'b0, act_strobe}, 64'd0);
    chk("t4_cnt_keep", {48'b0, frame_cnt}, 64'd2);
    chk("t4_bus_keep", wd(0), 64'd100);
    step();
    chk("t4_err_off", {63'b0, frame_err}, 64'd0);
    for (int k = 0; k < 15; k++) send(16'(300 + k), k == 14);
    chk("t4_w0",  wd(0), 64'd300);
    chk("t4_w5",  wd(5), 64'd305);
    chk("t4_w14", wd(14), 64'd314);
    chk("t4_cnt", {48'b0, frame_cnt}, 64'd3);
    step();
    chk("t4_stb",     {63'b0, act_strobe}, 64'd1);
    chk("t4_err_clr", {63'b0, frame_err}, 64'd0);
    step();

    // T5: missing last
    for (int k = 0; k < 15; k++) send(16'(400 + k), 1'b0);
    chk("t5_w0",  wd(0), 64'd400);
    chk("t5_w14", wd(14), 64'd414);
    chk("t5_cnt", {48'b0, frame_cnt}, 64'd4);
    step();
    chk("t5_stb", {63'b0, act_strobe}, 64'd1);
    chk("t5_err", {63'b0, frame_err}, 64'd1);
    step();
    chk("t5_stb_off", {63'b0, act_strobe}, 64'd0);
    chk("t5_err_off", {63'b0, frame_err}, 64'd0);

    // T6: negative word handling
    send(16'hFF38, 1'b0);
    send(16'h0104, 1'b0);
    for (int k = 2; k < 15; k++) send(16'(k), k == 14);
`ifdef LAYER_ACT_CLAMP_EN
    exp_neg = 64'h0;
`else
    exp_neg = 64'hFF38;
`endif
    chk("t6_neg",  wd(0), exp_neg);
    chk("t6_pos",  wd(1), 64'h0104);
    chk("t6_cnt",  {48'b0, frame_cnt}, 64'd5);
    step(); step();

    // T7: reset mid-frame discards partial frame
    for (int k = 0; k < 5; k++) send(16'(600 + k), 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t7_bus_zero", {63'b0, |act_bus}, 64'd0);
    chk("t7_cnt",      {48'b0, frame_cnt}, 64'd0);
    for (int k = 0; k < 15; k++) send(16'(500 + k), k == 14);
    chk("t7_w0",  wd(0), 64'd500);
    chk("t7_w14", wd(14), 64'd514);
    chk("t7_cnt1", {48'b0, frame_cnt}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
